mixer_weight_sequencer: RTL and testbench

MIXER_WEIGHT_SEQUENCER -- requirements
Module: mixer_weight_sequencer

---
 rtl/mixer_weight_sequencer_pkg.sv | 25 ++
 rtl/mixer_weight_sequencer_if.sv | 14 +
 rtl/weight_ramp_unit.sv | 48 ++++
 rtl/mixer_weight_sequencer.sv | 130 +++++++++++++
 tb/tb_mixer_weight_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mixer_weight_sequencer_pkg.sv
// rtl/mixer_weight_sequencer_pkg.sv - shared widths, weights and state encoding for the mixer weight sequencer
package mixer_weight_sequencer_pkg;

    localparam int WIDTH_DEF       = 18;
    localparam int FRAC_DEF        = 14;
    localparam int UNITY           = 1 << FRAC_DEF;
    localparam int RAMP_STEP_DEF   = 64;
    localparam int W_GAMMA_RST_DEF = 6554;
    localparam int W_BETA_RST_DEF  = 4915;
    localparam int W_NOISE_RST_DEF = 3277;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_MUTED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_GAMMA   = 2'd0,
        SEL_BETA    = 2'd1,
        SEL_NOISE   = 2'd2,
        SEL_INVALID = 2'd3
    } sel_e;

endpackage

// File: rtl/mixer_weight_sequencer_if.sv
// rtl/mixer_weight_sequencer_if.sv - configuration write channel for the mixer weight sequencer
interface mixer_weight_sequencer_if
    import mixer_weight_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [1:0]              cfg_sel;
    logic signed [WIDTH-1:0] cfg_data;

    modport master (output cfg_valid, output cfg_sel, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_sel, input cfg_data, output cfg_ready);
endinterface

// File: rtl/weight_ramp_unit.sv
// rtl/weight_ramp_unit.sv - one weight channel: current value register stepping toward its effective target
module weight_ramp_unit
    import mixer_weight_sequencer_pkg::*;
#(
    parameter int                      WIDTH     = WIDTH_DEF,
    parameter int                      RAMP_STEP = RAMP_STEP_DEF,
    parameter logic signed [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step_en,
    input  logic signed [WIDTH-1:0] eff,
    output logic signed [WIDTH-1:0] cur,
    output logic                    at_eff,
    output logic                    at_zero
);
    localparam logic signed [WIDTH:0]   STEP_X = (WIDTH+1)'(RAMP_STEP);
    localparam logic signed [WIDTH-1:0] STEP_W = WIDTH'(RAMP_STEP);

    logic signed [WIDTH-1:0] cur_q, cur_d;
    logic signed [WIDTH:0]   diff;

    // One guard bit keeps eff - cur exact for any pair of in-range operands.
    always_comb begin
        diff  = {eff[WIDTH-1], eff} - {cur_q[WIDTH-1], cur_q};
        cur_d = cur_q;
        if (step_en) begin
            if (diff > STEP_X)
                cur_d = cur_q + STEP_W;
            else if (diff < -STEP_X)
                cur_d = cur_q - STEP_W;
            else
                cur_d = eff;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cur_q <= RST_VAL;
        else
            cur_q <= cur_d;
    end

    assign cur     = cur_q;
    assign at_eff  = (cur_q == eff);
    assign at_zero = (cur_q == '0);

endmodule

// File: rtl/mixer_weight_sequencer.sv
// rtl/mixer_weight_sequencer.sv - three-channel mixer weight sequencer with clamped targets, ramping and mute
module mixer_weight_sequencer
    import mixer_weight_sequencer_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int FRAC        = FRAC_DEF,
    parameter int RAMP_STEP   = RAMP_STEP_DEF,
    parameter int W_GAMMA_RST = W_GAMMA_RST_DEF,
    parameter int W_BETA_RST  = W_BETA_RST_DEF,
    parameter int W_NOISE_RST = W_NOISE_RST_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic                     mute_req,
    mixer_weight_sequencer_if.slave  cfg,
    output logic signed [WIDTH-1:0]  w_gamma,
    output logic signed [WIDTH-1:0]  w_beta,
    output logic signed [WIDTH-1:0]  w_noise,
    output logic                     ramp_busy,
    output logic                     muted,
    output logic                     cfg_err
);
    localparam logic signed [WIDTH-1:0] UNITY_W = WIDTH'(1 << FRAC);
    localparam logic signed [WIDTH-1:0] RST_W [3] = '{WIDTH'(W_GAMMA_RST), WIDTH'(W_BETA_RST), WIDTH'(W_NOISE_RST)};

    function automatic logic signed [WIDTH-1:0] clamp_w(input logic signed [WIDTH-1:0] v);
        if (v[WIDTH-1])
            return '0;
        else if (v > UNITY_W)
            return UNITY_W;
        else
            return v;
    endfunction

    state_e                  state_q, state_d;
    logic                    cfg_ready_q, cfg_ready_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    ramp_busy_q, ramp_busy_d;
    logic                    muted_q, muted_d;
    logic signed [WIDTH-1:0] tgt_q [3];
    logic signed [WIDTH-1:0] tgt_d [3];
    logic signed [WIDTH-1:0] eff [3];
    logic signed [WIDTH-1:0] cur [3];
    logic [2:0]              at_eff, at_zero;
    logic                    accept, step_en;

    // Handshake and target registers; a step in this cycle still sees tgt_q.
    always_comb begin
        accept      = cfg.cfg_valid && cfg_ready_q;
        cfg_ready_d = !accept;
        cfg_err_d   = accept && (cfg.cfg_sel == SEL_INVALID);
        tgt_d       = tgt_q;
        if (accept && (cfg.cfg_sel != SEL_INVALID))
            tgt_d[cfg.cfg_sel] = clamp_w(cfg.cfg_data);
    end

    always_comb begin
        for (int i = 0; i < 3; i++)
            eff[i] = mute_req ? '0 : tgt_q[i];
    end

    assign step_en = clk_en && (state_q == ST_RAMP);

    for (genvar g = 0; g < 3; g++) begin : g_ch
        weight_ramp_unit #(
            .WIDTH     (WIDTH),
            .RAMP_STEP (RAMP_STEP),
            .RST_VAL   (RST_W[g])
        ) u_ramp (
            .clk     (clk),
            .rst     (rst),
            .step_en (step_en),
            .eff     (eff[g]),
            .cur     (cur[g]),
            .at_eff  (at_eff[g]),
            .at_zero (at_zero[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            ramp_busy_q <= 1'b0;
            muted_q     <= 1'b0;
            tgt_q       <= RST_W;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            ramp_busy_q <= ramp_busy_d;
            muted_q     <= muted_d;
            tgt_q       <= tgt_d;
        end
    end

    // Transitions only happen on sample ticks, so clk_en low freezes the state.
    always_comb begin
        state_d = state_q;
        if (clk_en) begin
            case (state_q)
                ST_IDLE:  if (at_eff != 3'b111) state_d = ST_RAMP;
                ST_RAMP: begin
                    if (mute_req && (&at_zero))
                        state_d = ST_MUTED;
                    else if (!mute_req && (&at_eff))
                        state_d = ST_IDLE;
                end
                ST_MUTED: if (!mute_req) state_d = ST_RAMP;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ramp_busy_d = (state_d == ST_RAMP);
        muted_d     = (state_d == ST_MUTED);
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg_err       = cfg_err_q;
    assign ramp_busy     = ramp_busy_q;
    assign muted         = muted_q;
    assign w_gamma       = cur[0];
    assign w_beta        = cur[1];
    assign w_noise       = cur[2];

endmodule

// File: tb/tb_mixer_weight_sequencer.sv
// tb/tb_mixer_weight_sequencer.sv - self-checking bench for mixer_weight_sequencer
module tb_mixer_weight_sequencer;
    import mixer_weight_sequencer_pkg::*;

    localparam int W = WIDTH_DEF;

    logic clk = 1'b0;
    logic rst, clk_en, mute_req;
    logic signed [W-1:0] w_gamma, w_beta, w_noise;
    logic ramp_busy, muted, cfg_err;

    mixer_weight_sequencer_if cfg_if ();

    mixer_weight_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .mute_req  (mute_req),
        .cfg       (cfg_if),
        .w_gamma   (w_gamma),
        .w_beta    (w_beta),
        .w_noise   (w_noise),
        .ramp_busy (ramp_busy),
        .muted     (muted),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w0, w1, w2;
        int ready, err, busy, mut;
    } exp_t;

    exp_t sb_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int g_changes = 0;
    int frozen_changes = 0;

    int m_state, m_ready, m_err;
    int m_tgt [3];
    int m_cur [3];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ready = 1; m_err = 0;
        m_tgt = '{W_GAMMA_RST_DEF, W_BETA_RST_DEF, W_NOISE_RST_DEF};
        m_cur = m_tgt;
    endtask

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > UNITY) return UNITY;
        return v;
    endfunction

    function automatic int toward(input int c, input int e);
        if (e - c > RAMP_STEP_DEF) return c + RAMP_STEP_DEF;
        if (c - e > RAMP_STEP_DEF) return c - RAMP_STEP_DEF;
        return e;
    endfunction

    // Reference behaviour for one clock edge, computed from the inputs present before it.
    task automatic model_edge();
        int n_tgt [3];
        int n_cur [3];
        int eff [3];
        int n_state, d;
        bit acc, all_eff, all_zero;
        exp_t e;
        acc = cfg_if.cfg_valid && (m_ready == 1);
        n_tgt = m_tgt;
        d = cfg_if.cfg_data;
        if (acc && cfg_if.cfg_sel != 2'd3) n_tgt[cfg_if.cfg_sel] = clamp(d);
        all_eff = 1; all_zero = 1;
        for (int i = 0; i < 3; i++) begin
            eff[i] = mute_req ? 0 : m_tgt[i];
            if (m_cur[i] != eff[i]) all_eff = 0;
            if (m_cur[i] != 0) all_zero = 0;
        end
        n_cur = m_cur;
        n_state = m_state;
        if (clk_en) begin
            if (m_state == 0) begin
                if (!all_eff) n_state = 1;
            end else if (m_state == 1) begin
                for (int i = 0; i < 3; i++) n_cur[i] = toward(m_cur[i], eff[i]);
                if (mute_req && all_zero) n_state = 2;
                else if (!mute_req && all_eff) n_state = 0;
            end else begin
                if (!mute_req) n_state = 1;
            end
        end
        m_tgt = n_tgt; m_cur = n_cur; m_state = n_state;
        m_err = (acc && cfg_if.cfg_sel == 2'd3) ? 1 : 0;
        m_ready = acc ? 0 : 1;
        e.w0 = m_cur[0]; e.w1 = m_cur[1]; e.w2 = m_cur[2];
        e.ready = m_ready; e.err = m_err;
        e.busy = (m_state == 1) ? 1 : 0;
        e.mut = (m_state == 2) ? 1 : 0;
        sb_q.push_back(e);
    endtask

    task automatic check_dut();
        exp_t e;
        chk("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_w_gamma", w_gamma, e.w0);
            chk("sb_w_beta", w_beta, e.w1);
            chk("sb_w_noise", w_noise, e.w2);
            chk("sb_cfg_ready", cfg_if.cfg_ready, e.ready);
            chk("sb_cfg_err", cfg_err, e.err);
            chk("sb_ramp_busy", ramp_busy, e.busy);
            chk("sb_muted", muted, e.mut);
        end
    endtask

    task automatic step();
        bit en;
        logic signed [W-1:0] pg, pb, pn;
        en = clk_en; pg = w_gamma; pb = w_beta; pn = w_noise;
        model_edge();
        @(posedge clk);
        #1;
        check_dut();
        if (w_gamma !== pg) g_changes++;
        if (!en && (w_gamma !== pg || w_beta !== pb || w_noise !== pn)) frozen_changes++;
    endtask

    task automatic write(input logic [1:0] sel, input int data);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_sel = sel;
        cfg_if.cfg_data = W'(data);
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic run_until(input string tag, input bit want_muted, input int max_steps);
        bit done;
        int n;
        done = 0; n = 0;
        while (!done && n < max_steps) begin
            step();
            n++;
            if (n >= 2 && !ramp_busy && muted == want_muted) done = 1;
        end
        chk({tag, "_settled"}, done, 1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_w_gamma"}, w_gamma, W_GAMMA_RST_DEF);
        chk({tag, "_w_beta"}, w_beta, W_BETA_RST_DEF);
        chk({tag, "_w_noise"}, w_noise, W_NOISE_RST_DEF);
        chk({tag, "_cfg_ready"}, cfg_if.cfg_ready, 1);
        chk({tag, "_cfg_err"}, cfg_err, 0);
        chk({tag, "_ramp_busy"}, ramp_busy, 0);
        chk({tag, "_muted"}, muted, 0);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; mute_req = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_sel = 2'd0; cfg_if.cfg_data = '0;
        model_reset();
        #2;
        chk_reset_values("reset");
        #1 rst = 1'b0;

        // Invalid-select write on the very first edge after release.
        write(2'd3, 5000);
        chk("first_edge_err", cfg_err, 1);
        chk("first_edge_ready", cfg_if.cfg_ready, 0);
        step();
        chk("err_one_cycle", cfg_err, 0);
        chk("invalid_no_ramp", ramp_busy, 0);
        chk("invalid_gamma_kept", w_gamma, W_GAMMA_RST_DEF);

        mute_req = 1'b1;
        g_changes = 0;
        run_until("mute", 1'b1, 300);
        chk("mute_gamma_ticks", g_changes, 103);
        chk("mute_w_gamma", w_gamma, 0);
        chk("mute_w_beta", w_beta, 0);
        chk("mute_w_noise", w_noise, 0);
        chk("mute_flag", muted, 1);
        mute_req = 1'b0;
        run_until("unmute", 1'b0, 300);
        chk("unmute_w_gamma", w_gamma, W_GAMMA_RST_DEF);
        chk("unmute_w_beta", w_beta, W_BETA_RST_DEF);
        chk("unmute_w_noise", w_noise, W_NOISE_RST_DEF);

        write(2'd0, 7194);
        g_changes = 0;
        step();
        chk("gamma_busy", ramp_busy, 1);
        run_until("gamma", 1'b0, 100);
        chk("gamma_ticks", g_changes, 10);
        chk("gamma_final", w_gamma, 7194);

        write(2'd1, 20000);
        run_until("beta_hi", 1'b0, 400);
        chk("beta_clamp_hi", w_beta, UNITY);
        write(2'd1, -5);
        run_until("beta_lo", 1'b0, 400);
        chk("beta_clamp_lo", w_beta, 0);

        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sel = 2'd2; cfg_if.cfg_data = W'(1000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b2b_ready", cfg_if.cfg_ready, (i % 2 == 0) ? 0 : 1);
        end
        cfg_if.cfg_valid = 1'b0;
        step();
        write(2'd3, 9000);
        chk("sel3_err", cfg_err, 1);
        step();
        chk("sel3_err_drop", cfg_err, 0);
        run_until("noise", 1'b0, 400);
        chk("noise_final", w_noise, 1000);
        chk("sel3_gamma_kept", w_gamma, 7194);
        chk("sel3_beta_kept", w_beta, 0);

        write(2'd0, 0);
        frozen_changes = 0;
        for (int i = 0; i < 20; i++) begin
            clk_en = (i % 4 == 0);
            step();
        end
        chk("frozen_changes", frozen_changes, 0);
        chk("busy_before_rst", ramp_busy, 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_reset_values("midramp_rst");
        #2 rst = 1'b0;
        clk_en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("post_rst_gamma", w_gamma, W_GAMMA_RST_DEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
